// File: rtl/litepcie_axis_pkg.sv
// Shared constants for the two-requester AXI-stream arbiter: FSM state encoding
// and the depth of the output skid buffer.
package litepcie_axis_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPkt0 = 2'd1,
    StPkt1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] SkidDepth = 2'd2;

endpackage

// File: rtl/axis_skid.sv
// Two-entry skid buffer; entry 0 is always the oldest and drives the read side.
module axis_skid
  import litepcie_axis_pkg::*;
#(
  parameter int unsigned Width = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [Width-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [Width-1:0] rd_dat,
  input  logic             rd_rdy
);

  logic [Width-1:0] ent0_q, ent1_q;
  logic [1:0]       cnt_q;
  logic             wr, rd;

  assign wr_rdy = (cnt_q < SkidDepth);
  assign rd_vld = (cnt_q != 2'd0);
  assign rd_dat = ent0_q;
  assign wr     = wr_vld && wr_rdy;
  assign rd     = rd_vld && rd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else begin
      case ({wr, rd})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= wr_dat;
          else               ent1_q <= wr_dat;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        // Write and read together only happen with one entry held: replace the head.
        2'b11: ent0_q <= wr_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_arb.sv
// Packet-level round-robin arbiter merging two AXI-style streams into one, with
// framing-error detection and a registered skid-buffered output.
module axis_arb
  import litepcie_axis_pkg::*;
#(
  parameter int unsigned DAT_B = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_vld,
  input  logic             i0_sop,
  input  logic             i0_eop,
  input  logic [DAT_B-1:0] i0_dat,
  output logic             o0_rdy,
  input  logic             i1_vld,
  input  logic             i1_sop,
  input  logic             i1_eop,
  input  logic [DAT_B-1:0] i1_dat,
  output logic             o1_rdy,
  output logic             o_vld,
  output logic             o_sop,
  output logic             o_eop,
  output logic [DAT_B-1:0] o_dat,
  input  logic             i_rdy,
  output logic             o_src,
  output logic             o_err
);

  arb_state_e       state_q;
  logic             lst_q, first_q, err_q;
  logic             sel, skid_rdy, acc;
  logic             in_vld, in_sop, in_eop;
  logic [DAT_B-1:0] in_dat;
  logic [DAT_B+2:0] wr_dat, rd_dat;

  always_comb begin
    sel    = (state_q == StPkt1);
    in_vld = sel ? i1_vld : i0_vld;
    in_sop = sel ? i1_sop : i0_sop;
    in_eop = sel ? i1_eop : i0_eop;
    in_dat = sel ? i1_dat : i0_dat;
  end

  assign o0_rdy = (state_q == StPkt0) && skid_rdy;
  assign o1_rdy = (state_q == StPkt1) && skid_rdy;
  assign acc    = in_vld && (o0_rdy || o1_rdy);
  assign wr_dat = {sel, in_sop, in_eop, in_dat};
  assign {o_src, o_sop, o_eop, o_dat} = rd_dat;
  assign o_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lst_q   <= 1'b1;
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      // sop must be set on exactly the first beat of a grant.
      err_q <= acc && (first_q ^ in_sop);
      if (acc) first_q <= in_eop;
      case (state_q)
        StIdle: begin
          if (i0_vld && i1_vld) state_q <= lst_q ? StPkt0 : StPkt1;
          else if (i0_vld)      state_q <= StPkt0;
          else if (i1_vld)      state_q <= StPkt1;
        end
        StPkt0, StPkt1: begin
          if (acc && in_eop) begin
            state_q <= StIdle;
            lst_q   <= sel;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_skid #(
    .Width(DAT_B + 3)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (acc),
    .wr_dat (wr_dat),
    .wr_rdy (skid_rdy),
    .rd_vld (o_vld),
    .rd_dat (rd_dat),
    .rd_rdy (i_rdy)
  );

endmodule

// File: tb/tb_axis_arb.sv
// Scoreboard bench for axis_arb: requester drivers feed beat queues, a monitor
// pops hand-ordered expected beats whenever the output handshakes.
module tb_axis_arb;

  localparam int unsigned DatB = 32;

  typedef struct packed {
    logic            src;
    logic            sop;
    logic            eop;
    logic [DatB-1:0] dat;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i0_vld = 1'b0, i0_sop = 1'b0, i0_eop = 1'b0;
  logic [DatB-1:0] i0_dat = '0;
  logic            i1_vld = 1'b0, i1_sop = 1'b0, i1_eop = 1'b0;
  logic [DatB-1:0] i1_dat = '0;
  logic            o0_rdy, o1_rdy, o_vld, o_sop, o_eop, o_src, o_err;
  logic [DatB-1:0] o_dat;
  logic            i_rdy = 1'b1;

  int    errors = 0, checks = 0, cyc = 0, err_hi = 0, err_rise = 0;
  logic  err_prev = 1'b0;
  beat_t q0[$], q1[$], exp_q[$];
  int    out_cyc[$];

  always #5 clk = ~clk;

  axis_arb #(.DAT_B(DatB)) dut (
    .clk(clk), .rst(rst),
    .i0_vld(i0_vld), .i0_sop(i0_sop), .i0_eop(i0_eop), .i0_dat(i0_dat), .o0_rdy(o0_rdy),
    .i1_vld(i1_vld), .i1_sop(i1_sop), .i1_eop(i1_eop), .i1_dat(i1_dat), .o1_rdy(o1_rdy),
    .o_vld(o_vld), .o_sop(o_sop), .o_eop(o_eop), .o_dat(o_dat),
    .i_rdy(i_rdy), .o_src(o_src), .o_err(o_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_beat(input logic src, input logic sop, input logic eop,
                          input logic [DatB-1:0] dat);
    beat_t b;
    b = '{src: src, sop: sop, eop: eop, dat: dat};
    if (src) q1.push_back(b);
    else     q0.push_back(b);
  endtask

  task automatic exp_beat(input logic src, input logic sop, input logic eop,
                          input logic [DatB-1:0] dat);
    exp_q.push_back('{src: src, sop: sop, eop: eop, dat: dat});
  endtask

  task automatic add_pkt(input logic src, input int n, input logic [DatB-1:0] base);
    for (int i = 0; i < n; i++) add_beat(src, i == 0, i == n - 1, base + DatB'(i));
  endtask

  task automatic exp_pkt(input logic src, input int n, input logic [DatB-1:0] base);
    for (int i = 0; i < n; i++) exp_beat(src, i == 0, i == n - 1, base + DatB'(i));
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !o_vld) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d beats still owed after 300 cycles, required 0", name,
               exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete();
    i0_vld = 1'b0; i1_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Requester 0 driver: a beat leaves the queue after a sampled handshake.
  always begin : drv0
    bit fire;
    @(negedge clk);
    fire = i0_vld && o0_rdy && !rst;
    @(posedge clk);
    #1;
    if (fire && q0.size() > 0) void'(q0.pop_front());
    if (q0.size() > 0) begin
      i0_vld = 1'b1; i0_sop = q0[0].sop; i0_eop = q0[0].eop; i0_dat = q0[0].dat;
    end else begin
      i0_vld = 1'b0;
    end
  end

  always begin : drv1
    bit fire;
    @(negedge clk);
    fire = i1_vld && o1_rdy && !rst;
    @(posedge clk);
    #1;
    if (fire && q1.size() > 0) void'(q1.pop_front());
    if (q1.size() > 0) begin
      i1_vld = 1'b1; i1_sop = q1[0].sop; i1_eop = q1[0].eop; i1_dat = q1[0].dat;
    end else begin
      i1_vld = 1'b0;
    end
  end

  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst && o_vld && i_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat: got %0h, required no beat", {o_src, o_sop, o_eop, o_dat});
      end else begin
        e = exp_q.pop_front();
        check("beat", {29'd0, o_src, o_sop, o_eop, o_dat}, {29'd0, e});
      end
      out_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin : err_mon
    if (!rst) begin
      if (o_err) err_hi++;
      if (o_err && !err_prev) err_rise++;
      err_prev = o_err;
    end
  end

  initial begin
    int    e0, r0;
    bit    seen;
    logic [63:0] held;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o_vld", o_vld, 0);
    check("rst_o_err", o_err, 0);
    check("rst_o0_rdy", o0_rdy, 0);
    check("rst_o1_rdy", o1_rdy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", {o0_rdy, o1_rdy}, 0);

    // Single source, 3-beat packet
    e0 = err_hi;
    out_cyc.delete();
    add_pkt(0, 3, 32'h100);
    exp_pkt(0, 3, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (i0_vld) seen = 1'b1;
    end
    check("vld_seen", seen, 1);
    check("rdy_idle_cycle", o0_rdy, 0);
    @(negedge clk);
    check("rdy_cycle1", o0_rdy, 1);
    wait_drain("single");
    if (out_cyc.size() == 3) check("single_consec", out_cyc[2] - out_cyc[0], 2);
    else check("single_count", out_cyc.size(), 3);
    check("single_err", err_hi - e0, 0);

    // Tie after reset: 0,1,0,1 with one bubble between packets
    do_reset();
    out_cyc.delete();
    add_pkt(0, 2, 32'hA00); add_pkt(0, 2, 32'hC00);
    add_pkt(1, 2, 32'hB00); add_pkt(1, 2, 32'hD00);
    exp_pkt(0, 2, 32'hA00); exp_pkt(1, 2, 32'hB00);
    exp_pkt(0, 2, 32'hC00); exp_pkt(1, 2, 32'hD00);
    wait_drain("tie");
    if (out_cyc.size() == 8) begin
      check("tie_in_pkt", out_cyc[1] - out_cyc[0], 1);
      check("tie_bubble", out_cyc[2] - out_cyc[1], 2);
    end else begin
      check("tie_count", out_cyc.size(), 8);
    end

    // Backpressure: output stalls 5 cycles mid-packet
    out_cyc.delete();
    add_pkt(0, 6, 32'h300);
    exp_pkt(0, 6, 32'h300);
    for (int i = 0; i < 20 && out_cyc.size() < 2; i++) @(negedge clk);
    @(posedge clk);
    #1 i_rdy = 1'b0;
    held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("bp_vld", o_vld, 1);
        held = {29'd0, o_src, o_sop, o_eop, o_dat};
      end else begin
        check("bp_hold", {29'd0, o_src, o_sop, o_eop, o_dat}, held);
      end
    end
    check("bp_full_rdy", o0_rdy, 0);
    @(posedge clk);
    #1 i_rdy = 1'b1;
    wait_drain("bp");

    // Framing errors; lst is 0 here so requester 1 wins the tie
    e0 = err_hi;
    r0 = err_rise;
    add_pkt(1, 2, 32'h500);
    add_beat(0, 0, 0, 32'h400); add_beat(0, 0, 0, 32'h401);
    add_beat(0, 1, 0, 32'h402); add_beat(0, 0, 1, 32'h403);
    exp_pkt(1, 2, 32'h500);
    exp_beat(0, 0, 0, 32'h400); exp_beat(0, 0, 0, 32'h401);
    exp_beat(0, 1, 0, 32'h402); exp_beat(0, 0, 1, 32'h403);
    wait_drain("frame");
    check("frame_err_cycles", err_hi - e0, 2);
    check("frame_err_pulses", err_rise - r0, 2);

    // Reset on beat 2 of 4; lst would otherwise favour requester 1
    add_pkt(0, 4, 32'h600);
    exp_pkt(0, 4, 32'h600);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i0_vld && o0_rdy && q0.size() == 3) seen = 1'b1;
    end
    check("rst_mid_seen", seen, 1);
    rst = 1'b1;
    q0.delete(); exp_q.delete();
    i0_vld = 1'b0;
    @(negedge clk);
    check("rst_mid_o_vld", o_vld, 0);
    check("rst_mid_rdy", {o0_rdy, o1_rdy}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", {o0_rdy, o1_rdy, o_vld}, 0);
    add_pkt(0, 1, 32'h700); add_pkt(1, 1, 32'h710);
    exp_pkt(0, 1, 32'h700); exp_pkt(1, 1, 32'h710);
    wait_drain("rst_tie");

    // Alternating single-beat packets
    e0 = err_hi;
    add_pkt(0, 1, 32'h800); add_pkt(0, 1, 32'h802);
    add_pkt(1, 1, 32'h801); add_pkt(1, 1, 32'h803);
    exp_pkt(0, 1, 32'h800); exp_pkt(1, 1, 32'h801);
    exp_pkt(0, 1, 32'h802); exp_pkt(1, 1, 32'h803);
    wait_drain("single_beat");
    check("single_beat_err", err_hi - e0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
